apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream stage of the APB interconnect. Converts a valid/ready request from the core-side bus into one APB transfer: SETUP phase, then ACCESS phase.
- Drives the interconnect's single-master APB inputs (address, write, select, enable, write data). Returns read data and error to the requester on a valid/ready response channel.
- Guards against hung peripherals with an ACCESS-phase timeout.
- Guards against unmapped windows (address bits [10:8] == 0) with an immediate decode error.

Parameters:
- ADDR_W, 12, APB address width; matches the interconnect address bus.
- DATA_W, 32, read/write data width.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles with ready_in low before abort; legal range 1..65535.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  bridge accepts request.
- req_addr  input  ADDR_W  request address.
- req_wr  input  1  1 = write, 0 = read.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  slave error, decode error or timeout.
- addr_out  output  ADDR_W  APB address, to interconnect addr_in.
- wr_out  output  1  APB write, to wr_in.
- sel_out  output  1  APB select, to sel.
- en_out  output  1  APB enable, to en_in.
- wdata_out  output  DATA_W  APB write data, to data_in.
- ready_in  input  1  from interconnect ready_out.
- rdata_in  input  DATA_W  from interconnect readdata.
- slverr_in  input  1  from interconnect PSLVERR.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset (rst low):
  - Takes effect immediately.
  - All outputs are 0, including req_ready.
  - Timeout counter and capture registers are cleared.
  - An in-flight transfer is dropped and produces no response.
- IDLE:
  - req_ready = 1. Handshake when req_valid && req_ready; req_addr, req_wr and req_wdata are captured at that edge.
  - If captured addr[10:8] == 3'b000: go to RESP with rsp_err = 1 and rsp_rdata = 0. No APB phase is issued; sel_out stays 0.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - sel_out = 1, en_out = 0.
  - addr_out, wr_out and wdata_out carry the captured values.
  - Next state is ACCESS. Counter cleared to 0.
- ACCESS:
  - sel_out = 1, en_out = 1; address, write and data are held stable.
  - If ready_in = 1: capture rsp_err = slverr_in, and rsp_rdata = rdata_in for a read or 0 for a write. Go to RESP.
  - Else increment the counter. When the counter has reached TIMEOUT_CYCLES with ready_in still low, abort: rsp_err = 1, rsp_rdata = 0, go to RESP.
  - ready_in = 1 in the same cycle the timeout expires: ready wins and the transfer completes normally.
- RESP:
  - sel_out = en_out = 0; rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_ready. On the handshake edge go to IDLE.
  - req_ready = 0 throughout.
- APB outputs outside SETUP/ACCESS: addr_out, wdata_out and wr_out are 0.
- Latency:
  - Accept at edge N; SETUP in cycle N+1; zero-wait ACCESS in N+2; rsp_valid in N+3.
  - With rsp_ready held high, the next accept is at N+4, giving a maximum throughput of 1 transfer per 4 cycles.
  - Each ready_in wait state adds 1 cycle.
- No pipelining: at most one outstanding transfer.
- Width rules: no truncation; all ports match ADDR_W and DATA_W. The counter is 16 bits and saturates; it never wraps.
- Changes on req_* inputs after acceptance do not affect the transfer in progress.

Test Plan:
- Write, zero wait: req addr 0x104, wr = 1, wdata 0xDEADBEEF; ready_in = 1 in ACCESS.
  - Required: SETUP shows sel = 1, en = 0, addr_out = 0x104, wdata_out = 0xDEADBEEF.
  - Required: rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: addr 0x308; ready_in low for 3 ACCESS cycles, then high with rdata_in = 0x12345678.
  - Required: en_out high for 4 cycles, addr_out held at 0x308.
  - Required: rsp_rdata = 0x12345678, rsp_err = 0.
- Decode error: req addr 0x0FC.
  - Required: sel_out never asserts; rsp_valid 1 cycle after accept; rsp_err = 1, rsp_rdata = 0.
- Timeout: TIMEOUT_CYCLES = 4, addr 0x204, ready_in tied 0.
  - Required: en_out high for exactly 4 ACCESS cycles, then sel = en = 0; rsp_err = 1.
  - Repeat with ready_in = 1 on the 4th ACCESS cycle: normal completion, rsp_err = 0.
- Response backpressure and slave error: slverr_in = 1 with ready_in = 1 on a read of 0x510; rsp_ready held 0 for 5 cycles.
  - Required: rsp_valid, rsp_err = 1 and rsp_rdata stay stable; req_ready = 0 throughout.
  - Required: IDLE and req_ready = 1 on the cycle after the rsp_ready handshake.
- Reset mid-ACCESS: assert rst low during a wait state.
  - Required: sel_out, en_out, busy and rsp_valid go to 0 immediately.
  - Required: after rst is released, no stale response appears and a new request completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Bundle for the bridge: core-side valid/ready request and response channels plus the APB-side drive/return signals.
// "master" is the bridge's view of the bundle. "slave" is the view of whatever sits around the bridge.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] addr_out;
    logic              wr_out;
    logic              sel_out;
    logic              en_out;
    logic [DATA_W-1:0] wdata_out;
    logic              ready_in;
    logic [DATA_W-1:0] rdata_in;
    logic              slverr_in;
    logic              busy;

    modport master (
        input  req_valid, req_addr, req_wr, req_wdata, rsp_ready,
        input  ready_in, rdata_in, slverr_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output addr_out, wr_out, sel_out, en_out, wdata_out, busy
    );

    modport slave (
        output req_valid, req_addr, req_wr, req_wdata, rsp_ready,
        output ready_in, rdata_in, slverr_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  addr_out, wr_out, sel_out, en_out, wdata_out, busy
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a core-side valid/ready request to one APB transfer (SETUP then ACCESS).
// An ACCESS-phase timeout and a decode check on unmapped windows both return an error response.
module apb_master_bridge #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_master_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // A transfer is aborted on the ACCESS cycle that would make the low-ready count reach TIMEOUT_CYCLES.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wr_d    = bus.req_wr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    // Window 0 is unmapped: answer straight away without touching the APB bus.
                    if (bus.req_addr[10:8] == 3'b000) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.ready_in) begin
                    err_d   = bus.slverr_in;
                    rdata_d = wr_q ? '0 : bus.rdata_in;
                    state_d = RESP;
                end else if (cnt_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic apb_active;

    always_comb begin
        apb_active    = (state_q == SETUP) || (state_q == ACCESS);
        bus.req_ready = rst && (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.sel_out   = apb_active;
        bus.en_out    = (state_q == ACCESS);
        bus.addr_out  = apb_active ? addr_q : '0;
        bus.wr_out    = apb_active && wr_q;
        bus.wdata_out = apb_active ? wdata_q : '0;
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        bus.rsp_err   = (state_q == RESP) && err_q;
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized transfers through apb_master_bridge (timeout set to 4 ACCESS cycles),
// each checked against a transaction-level model of the expected response and APB phase counts.
module tb_apb_master_bridge;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request; ready_in is held low for 'waits' ACCESS cycles, then high.
    task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                           input int waits, input logic se, input logic [DW-1:0] rd, input int bp);
        logic          decode, tmo, exp_err, addr_bad, got;
        logic [DW-1:0] exp_rd;
        int            exp_en, exp_lat, c, en_cnt, sel_cnt;
        decode  = (a[10:8] == 3'b000);
        tmo     = !decode && (waits >= TO);
        exp_en  = decode ? 0 : (tmo ? TO : waits + 1);
        exp_lat = decode ? 1 : (tmo ? TO + 2 : waits + 3);
        exp_err = decode || tmo || se;
        exp_rd  = (decode || tmo || w) ? '0 : rd;

        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wr    = w;
        bus.req_wdata = wd;
        bus.ready_in  = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = AW'($urandom);
        bus.req_wr    = ~w;
        bus.req_wdata = $urandom;

        c = 0; en_cnt = 0; sel_cnt = 0; got = 1'b0; addr_bad = 1'b0;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            if (bus.sel_out) sel_cnt++;
            if (c == 1 && !decode) begin
                chk("setup_sel", 64'(bus.sel_out), 64'(1));
                chk("setup_en", 64'(bus.en_out), 64'(0));
                chk("setup_addr", 64'(bus.addr_out), 64'(a));
                chk("setup_wdata", 64'(bus.wdata_out), 64'(wd));
                chk("setup_wr", 64'(bus.wr_out), 64'(w));
            end
            if (bus.en_out) begin
                en_cnt++;
                if (bus.addr_out !== a || bus.wdata_out !== wd || bus.wr_out !== w) addr_bad = 1'b1;
                bus.ready_in = (en_cnt > waits);
                bus.rdata_in  = bus.ready_in ? rd : $urandom;
                bus.slverr_in = bus.ready_in ? se : 1'($urandom);
            end else begin
                bus.ready_in = 1'b0;
            end
            if (bus.rsp_valid) got = 1'b1;
        end
        bus.ready_in = 1'b0;

        chk("rsp_latency", 64'(c), 64'(exp_lat));
        chk("en_cycles", 64'(en_cnt), 64'(exp_en));
        chk("sel_cycles", 64'(sel_cnt), 64'(decode ? 0 : exp_en + 1));
        chk("apb_held", 64'(addr_bad), 64'(0));
        chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        chk("resp_addr_zero", 64'(bus.addr_out), 64'(0));
        chk("resp_req_ready", 64'(bus.req_ready), 64'(0));

        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("bp_err", 64'(bus.rsp_err), 64'(exp_err));
            chk("bp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
            chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_valid", 64'(bus.rsp_valid), 64'(0));
        chk("post_req_ready", 64'(bus.req_ready), 64'(1));
        chk("post_busy", 64'(bus.busy), 64'(0));
        $display("txn addr=%h wr=%b waits=%0d bp=%0d -> err=%b rdata=%h latency=%0d",
                 a, w, waits, bp, exp_err, exp_rd, c);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wr    = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.ready_in  = 1'b0;
        bus.rdata_in  = '0;
        bus.slverr_in = 1'b0;

        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_sel", 64'(bus.sel_out), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_txn(12'h104, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
        run_txn(12'h308, 1'b0, 32'h0, 3, 1'b0, 32'h12345678, 0);
        run_txn(12'h0FC, 1'b0, 32'h0, 0, 1'b0, 32'hAAAA5555, 0);
        run_txn(12'h204, 1'b0, 32'h0, 10, 1'b0, 32'h11111111, 0);
        run_txn(12'h204, 1'b0, 32'h0, 3, 1'b0, 32'h22222222, 0);
        run_txn(12'h510, 1'b0, 32'h0, 0, 1'b1, 32'hCAFEF00D, 4);

        // Reset during an ACCESS wait state.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'h308;
        bus.req_wr    = 1'b0;
        bus.ready_in  = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_en", 64'(bus.en_out), 64'(1));
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_sel", 64'(bus.sel_out), 64'(0));
        chk("mid_rst_en", 64'(bus.en_out), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy), 64'(0));
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        bus.rsp_ready = 1'b0;
        run_txn(12'h404, 1'b0, 32'h0, 1, 1'b0, 32'h0BADCAFE, 0);

        for (int n = 0; n < 40; n++) begin
            run_txn(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 6)),
                    1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
